udp_rx: RTL

//  Receive path of the 10G UDP stack; mirror of udp_tx. Takes the 64-bit AXIS IP payload (IP header

---
 rtl/udp_rx_if.sv | 15 +
 rtl/udp_rx.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/udp_rx_if.sv
// udp_rx_if: 64-bit AXI-Stream bundle for the UDP receive path.
// master drives data/control, slave returns tready.
interface udp_rx_if;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tuser;
  logic        tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser,
                  output tready);
endinterface

// File: rtl/udp_rx.sv
// udp_rx: parses the UDP header, filters on dst port, trims padding by the length field.
// Define UDP_RX_STATS_EN to add saturating good/drop/trunc datagram counters.
module udp_rx #(
  parameter bit PORT_FILTER = 1'b1
`ifdef UDP_RX_STATS_EN
  ,
  parameter int unsigned CNT_WIDTH = 32
`endif
) (
  input  logic        rx_axis_aclk,
  input  logic        rx_axis_areset,
  input  logic [15:0] udp_local_port,
  udp_rx_if.slave     ip_rx_axis,
  udp_rx_if.master    udp_rx_axis,
  output logic [15:0] udp_rx_src_port,
  output logic [15:0] udp_rx_dst_port,
  output logic [15:0] udp_rx_length
`ifdef UDP_RX_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stat_rx_good,
  output logic [CNT_WIDTH-1:0] stat_rx_drop,
  output logic [CNT_WIDTH-1:0] stat_rx_trunc
`endif
);

  typedef enum logic [1:0] {StHdr, StPayload, StDrain, StDrop} state_e;

  state_e      state_q;
  logic [15:0] rem_q;
  logic        out_valid_q, out_last_q, out_user_q;
  logic [63:0] out_data_q;
  logic [7:0]  out_keep_q;
  logic        pend_valid_q;
  logic [15:0] pend_src_q, pend_dst_q, pend_len_q;

  logic [15:0] hdr_src, hdr_dst, hdr_len;
  logic        hdr_drop;
  logic        in_ready, in_fire, out_fire, out_free;
  logic [3:0]  nb;
  logic        end_hit;
  logic [7:0]  trim_keep;
  logic        unused_bits;

  assign hdr_src  = {ip_rx_axis.tdata[7:0],   ip_rx_axis.tdata[15:8]};
  assign hdr_dst  = {ip_rx_axis.tdata[23:16], ip_rx_axis.tdata[31:24]};
  assign hdr_len  = {ip_rx_axis.tdata[39:32], ip_rx_axis.tdata[47:40]};
  assign hdr_drop = (PORT_FILTER && (hdr_dst != udp_local_port)) || (hdr_len < 16'd8);
  // Checksum lanes and input tuser carry nothing this block needs.
  assign unused_bits = ^{ip_rx_axis.tdata[63:48], ip_rx_axis.tuser};

  assign out_fire = out_valid_q && udp_rx_axis.tready;
  assign out_free = !out_valid_q || udp_rx_axis.tready;
  assign in_ready = !rx_axis_areset && ((state_q == StPayload) ? out_free : 1'b1);
  assign in_fire  = ip_rx_axis.tvalid && in_ready;

  always_comb begin
    nb = '0;
    for (int i = 0; i < 8; i++) nb = nb + {3'd0, ip_rx_axis.tkeep[i]};
  end

  assign end_hit = (rem_q <= 16'd8) && (rem_q <= {12'd0, nb});

  always_comb begin
    trim_keep = '0;
    for (int i = 0; i < 8; i++) trim_keep[i] = (16'(i) < rem_q);
  end

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      state_q         <= StHdr;
      rem_q           <= '0;
      out_valid_q     <= 1'b0;
      out_last_q      <= 1'b0;
      out_user_q      <= 1'b0;
      out_data_q      <= '0;
      out_keep_q      <= '0;
      pend_valid_q    <= 1'b0;
      pend_src_q      <= '0;
      pend_dst_q      <= '0;
      pend_len_q      <= '0;
      udp_rx_src_port <= '0;
      udp_rx_dst_port <= '0;
      udp_rx_length   <= '0;
    end else begin
      if (out_fire) out_valid_q <= 1'b0;
      // Header metadata waits here until the previous datagram has left the output register.
      if (pend_valid_q && out_free) begin
        udp_rx_src_port <= pend_src_q;
        udp_rx_dst_port <= pend_dst_q;
        udp_rx_length   <= pend_len_q;
        pend_valid_q    <= 1'b0;
      end
      unique case (state_q)
        StHdr: begin
          if (in_fire) begin
            if (!hdr_drop) begin
              pend_valid_q <= 1'b1;
              pend_src_q   <= hdr_src;
              pend_dst_q   <= hdr_dst;
              pend_len_q   <= hdr_len;
            end
            if (ip_rx_axis.tlast || (!hdr_drop && (hdr_len == 16'd8))) begin
              state_q <= StHdr;
            end else if (hdr_drop) begin
              state_q <= StDrop;
            end else begin
              state_q <= StPayload;
              rem_q   <= hdr_len - 16'd8;
            end
          end
        end
        StPayload: begin
          if (in_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= ip_rx_axis.tdata;
            if (end_hit) begin
              out_keep_q <= trim_keep;
              out_last_q <= 1'b1;
              out_user_q <= 1'b0;
              state_q    <= ip_rx_axis.tlast ? StHdr : StDrain;
            end else if (ip_rx_axis.tlast) begin
              out_keep_q <= ip_rx_axis.tkeep;
              out_last_q <= 1'b1;
              out_user_q <= 1'b1;
              state_q    <= StHdr;
            end else begin
              out_keep_q <= ip_rx_axis.tkeep;
              out_last_q <= 1'b0;
              out_user_q <= 1'b0;
              rem_q      <= rem_q - {12'd0, nb};
            end
          end
        end
        StDrain, StDrop: begin
          if (in_fire && ip_rx_axis.tlast) state_q <= StHdr;
        end
        default: state_q <= StHdr;
      endcase
    end
  end

  assign ip_rx_axis.tready  = in_ready;
  assign udp_rx_axis.tdata  = out_data_q;
  assign udp_rx_axis.tkeep  = out_keep_q;
  assign udp_rx_axis.tvalid = out_valid_q;
  assign udp_rx_axis.tlast  = out_last_q;
  assign udp_rx_axis.tuser  = out_user_q;

`ifdef UDP_RX_STATS_EN
  logic out_done, hdr_to_drop;
  assign out_done    = out_fire && out_last_q;
  assign hdr_to_drop = in_fire && (state_q == StHdr) && !ip_rx_axis.tlast && hdr_drop;

  always_ff @(posedge rx_axis_aclk) begin
    if (rx_axis_areset) begin
      stat_rx_good  <= '0;
      stat_rx_drop  <= '0;
      stat_rx_trunc <= '0;
    end else begin
      if (out_done && !out_user_q && !(&stat_rx_good)) stat_rx_good <= stat_rx_good + CNT_WIDTH'(1);
      if (out_done && out_user_q && !(&stat_rx_trunc)) begin
        stat_rx_trunc <= stat_rx_trunc + CNT_WIDTH'(1);
      end
      if (hdr_to_drop && !(&stat_rx_drop)) stat_rx_drop <= stat_rx_drop + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
